// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Raster timing generator. A clock divider produces a pixel tick, and the tick
// advances the H/V position counters over a programmable line/frame timing.
// Sync, video-on and the line/frame strobes are registered and decoded from the
// next-state counter values, so they line up with pix_x/pix_y with zero skew.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-high
//   run          in   1 = scan, 0 = hold at origin with idle outputs
//   pix_tick     out  one-cycle pulse in the cycle the counters advance
//   pix_x        out  horizontal position, 0..H_TOTAL-1
//   pix_y        out  vertical position, 0..V_TOTAL-1
//   hsync        out  horizontal sync, active level HS_POL
//   vsync        out  vertical sync, active level VS_POL
//   vid_on       out  inside the visible area
//   line_start   out  one-cycle pulse, pix_x just wrapped to 0
//   frame_start  out  one-cycle pulse, (pix_x,pix_y) just wrapped to (0,0)
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 4,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned CW       = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    output logic          pix_tick,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          hsync,
    output logic          vsync,
    output logic          vid_on,
    output logic          line_start,
    output logic          frame_start
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_FIRST = H_ACTIVE + H_FP;
    localparam int unsigned HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int unsigned VS_FIRST = V_ACTIVE + V_FP;
    localparam int unsigned VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;
    localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Reject timings the counters cannot represent
    if (CLK_DIV < 1 || 64'(H_TOTAL) > (64'(1) << CW) || 64'(V_TOTAL) > (64'(1) << CW)) begin : g_bad_cfg
        $error("vga_timing_gen: CLK_DIV must be >= 1 and H_TOTAL/V_TOTAL must fit in CW bits");
    end

    logic [DW-1:0] div_q,         div_d;
    logic [CW-1:0] pix_x_q,       pix_x_d;
    logic [CW-1:0] pix_y_q,       pix_y_d;
    logic          pix_tick_q,    pix_tick_d;
    logic          hsync_q,       hsync_d;
    logic          vsync_q,       vsync_d;
    logic          vid_on_q,      vid_on_d;
    logic          line_start_q,  line_start_d;
    logic          frame_start_q, frame_start_d;

    logic tick_c;
    logic x_last_c;
    logic y_last_c;

    assign tick_c   = (div_q == DW'(CLK_DIV - 1));
    assign x_last_c = (pix_x_q == CW'(H_TOTAL - 1));
    assign y_last_c = (pix_y_q == CW'(V_TOTAL - 1));

    // Next-state counters, then decode of the outputs from those next values
    always_comb begin
        div_d         = div_q;
        pix_x_d       = pix_x_q;
        pix_y_d       = pix_y_q;
        pix_tick_d    = 1'b0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        hsync_d       = ~HS_POL;
        vsync_d       = ~VS_POL;
        vid_on_d      = 1'b0;

        if (!run) begin
            // Stopped: park at the origin, idle outputs, no strobes
            div_d   = '0;
            pix_x_d = '0;
            pix_y_d = '0;
        end else begin
            if (tick_c) begin
                div_d      = '0;
                pix_tick_d = 1'b1;
                if (x_last_c) begin
                    pix_x_d      = '0;
                    line_start_d = 1'b1;
                    if (y_last_c) begin
                        pix_y_d       = '0;
                        frame_start_d = 1'b1;
                    end else begin
                        pix_y_d = pix_y_q + CW'(1);
                    end
                end else begin
                    pix_x_d = pix_x_q + CW'(1);
                end
            end else begin
                div_d = div_q + DW'(1);
            end

            hsync_d  = (pix_x_d >= CW'(HS_FIRST) && pix_x_d <= CW'(HS_LAST)) ? HS_POL : ~HS_POL;
            vsync_d  = (pix_y_d >= CW'(VS_FIRST) && pix_y_d <= CW'(VS_LAST)) ? VS_POL : ~VS_POL;
            vid_on_d = (pix_x_d <= CW'(H_ACTIVE - 1)) && (pix_y_d <= CW'(V_ACTIVE - 1));
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q         <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_tick_q    <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            vid_on_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_tick_q    <= pix_tick_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            vid_on_q      <= vid_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_tick    = pix_tick_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign vid_on      = vid_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule
